sar_ctrl: RTL and testbench

SAR_CTRL -- requirements
Module: sar_ctrl

---
 rtl/sar_pkg.sv | 16 +
 rtl/sar_reg.sv | 58 +++++
 rtl/sar_ctrl.sv | 121 ++++++++++++
 tb/tb_sar_ctrl.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/sar_pkg.sv
// rtl/sar_pkg.sv - shared state encoding and default parameters for the SAR controller
package sar_pkg;

   // Default resolution and track-phase length
   localparam int SAR_N_DEF          = 8;
   localparam int SAR_SAMPLE_CYC_DEF = 2;

   // Controller states
   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_SAMPLE = 2'd1,
      S_CONV   = 2'd2,
      S_DONE   = 2'd3
   } sar_state_t;

endpackage

// File: rtl/sar_reg.sv
// rtl/sar_reg.sv - successive-approximation register and bit pointer
module sar_reg
   import sar_pkg::*;
#(
   parameter int N = SAR_N_DEF
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clear,
   input  logic         start,
   input  logic         step,
   input  logic         cmp,
   output logic [N-1:0] code,
   output logic [N-1:0] resolved,
   output logic         last
);

   localparam int          IW  = $clog2(N);
   localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};
   localparam logic [IW-1:0] TOP = IW'(N - 1);

   logic [IW-1:0] idx;
   logic [N-1:0]  cur_mask;
   logic [N-1:0]  nxt_mask;

   // Trial bit under test, and the one below it that becomes the next trial
   always_comb begin
      cur_mask = ONE << idx;
      nxt_mask = '0;
      if (idx != '0) begin
         nxt_mask = ONE << (idx - IW'(1));
      end
   end

   // The trial bit is already set in code, so a 1 from the comparator just keeps it
   assign resolved = cmp ? code : (code & ~cur_mask);
   assign last     = (idx == '0);

   // Code/pointer update: clear beats start beats a bit-trial step
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         code <= '0;
         idx  <= TOP;
      end else if (clear) begin
         code <= '0;
         idx  <= TOP;
      end else if (start) begin
         code <= ONE << TOP;
         idx  <= TOP;
      end else if (step) begin
         code <= resolved | nxt_mask;
         if (idx != '0) begin
            idx <= idx - IW'(1);
         end
      end
   end

endmodule

// File: rtl/sar_ctrl.sv
// rtl/sar_ctrl.sv - SAR ADC conversion sequencer with registered outputs
module sar_ctrl
   import sar_pkg::*;
#(
   parameter int N          = SAR_N_DEF,
   parameter int SAMPLE_CYC = SAR_SAMPLE_CYC_DEF
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         en,
   input  logic         cmp_out,
   output logic         sample,
   output logic         cmp_en,
   output logic [N-1:0] dac_code,
   output logic [N-1:0] dout,
   output logic         dout_valid,
   output logic         busy
);

   sar_state_t   state;
   sar_state_t   state_nxt;
   logic [3:0]   samp_cnt;
   logic         sar_clear;
   logic         sar_start;
   logic         sar_step;
   logic         sar_last;
   logic [N-1:0] sar_resolved;
   logic         sample_d;
   logic         cmp_en_d;
   logic         busy_d;
   logic         valid_d;

   // State register
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Track-phase length counter, zero whenever we are not tracking
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         samp_cnt <= '0;
      end else if (state == S_SAMPLE) begin
         samp_cnt <= samp_cnt + 4'd1;
      end else begin
         samp_cnt <= '0;
      end
   end

   // Next-state logic; dropping en aborts tracking or trials straight to idle
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:   state_nxt = en ? S_SAMPLE : S_IDLE;
         S_SAMPLE: begin
            if (!en) begin
               state_nxt = S_IDLE;
            end else if (samp_cnt == 4'(SAMPLE_CYC - 1)) begin
               state_nxt = S_CONV;
            end
         end
         S_CONV: begin
            if (!en) begin
               state_nxt = S_IDLE;
            end else if (sar_last) begin
               state_nxt = S_DONE;
            end
         end
         S_DONE:   state_nxt = en ? S_SAMPLE : S_IDLE;
         default:  state_nxt = S_IDLE;
      endcase
   end

   // Output decode from the next state so the registered outputs line up with the state
   always_comb begin
      sample_d  = (state_nxt == S_SAMPLE);
      cmp_en_d  = (state_nxt == S_CONV);
      busy_d    = (state_nxt != S_IDLE);
      valid_d   = (state == S_CONV) && (state_nxt == S_DONE);
      sar_clear = (state_nxt == S_IDLE) || (state_nxt == S_SAMPLE);
      sar_start = (state_nxt == S_CONV) && (state != S_CONV);
      sar_step  = (state == S_CONV) && en;
   end

   // Output registers; dout captures the code including the final bit decision
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sample     <= 1'b0;
         cmp_en     <= 1'b0;
         busy       <= 1'b0;
         dout_valid <= 1'b0;
         dout       <= '0;
      end else begin
         sample     <= sample_d;
         cmp_en     <= cmp_en_d;
         busy       <= busy_d;
         dout_valid <= valid_d;
         if (valid_d) begin
            dout <= sar_resolved;
         end
      end
   end

   sar_reg #(
      .N (N)
   ) u_sar_reg (
      .clk      (clk),
      .rst_n    (rst_n),
      .clear    (sar_clear),
      .start    (sar_start),
      .step     (sar_step),
      .cmp      (cmp_out),
      .code     (dac_code),
      .resolved (sar_resolved),
      .last     (sar_last)
   );

endmodule

// File: tb/tb_sar_ctrl.sv
// tb/tb_sar_ctrl.sv - self-checking bench for sar_ctrl against a bit-trial reference model
module tb_sar_ctrl;

   localparam int N  = 8;
   localparam int SC = 2;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         en;
   logic         cmp_out = 1'b0;
   logic         sample;
   logic         cmp_en;
   logic [N-1:0] dac_code;
   logic [N-1:0] dout;
   logic         dout_valid;
   logic         busy;

   logic [N-1:0] vin = '0;
   logic [N-1:0] exp_dout = '0;
   int           n_vec = 0;
   int           n_err = 0;
   int           cyc = 0;
   int           last_valid = 0;
   bit           chain_prev = 1'b0;

   sar_ctrl #(
      .N          (N),
      .SAMPLE_CYC (SC)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .en         (en),
      .cmp_out    (cmp_out),
      .sample     (sample),
      .cmp_en     (cmp_en),
      .dac_code   (dac_code),
      .dout       (dout),
      .dout_valid (dout_valid),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Comparator model: decision latched mid-cycle from the settled DAC code
   always @(negedge clk) cmp_out <= (vin >= dac_code);

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h at cycle %0d", tag, got, exp, cyc);
      end
   endtask

   task automatic check_reset_vals();
      check("rst_sample", sample, 0);
      check("rst_cmp_en", cmp_en, 0);
      check("rst_dac", dac_code, 0);
      check("rst_dout", dout, 0);
      check("rst_valid", dout_valid, 0);
      check("rst_busy", busy, 0);
   endtask

   task automatic check_idle();
      check("idle_busy", busy, 0);
      check("idle_sample", sample, 0);
      check("idle_cmp_en", cmp_en, 0);
      check("idle_dac", dac_code, 0);
      check("idle_valid", dout_valid, 0);
      check("idle_dout", dout, exp_dout);
   endtask

   // Full conversion starting with the first SAMPLE cycle at the next negedge
   task automatic run_conv(input logic [N-1:0] v, input bit keep_en);
      logic [N-1:0] code;
      logic [N-1:0] trial;
      logic [N-1:0] trace [N];
      code = '0;
      for (int i = N - 1; i >= 0; i--) begin
         trial = code | (N'(1) << i);
         trace[N-1-i] = trial;
         if (v >= trial) code = trial;
      end
      vin = v;
      for (int c = 0; c < SC + N + 1; c++) begin
         @(negedge clk);
         check("busy", busy, 1);
         if (c < SC) begin
            check("samp_sample", sample, 1);
            check("samp_cmp_en", cmp_en, 0);
            check("samp_dac", dac_code, 0);
            check("samp_valid", dout_valid, 0);
         end else if (c < SC + N) begin
            check("conv_sample", sample, 0);
            check("conv_cmp_en", cmp_en, 1);
            check("conv_dac", dac_code, trace[c-SC]);
            check("conv_valid", dout_valid, 0);
         end else begin
            check("done_valid", dout_valid, 1);
            check("done_dout", dout, v);
            check("done_cmp_en", cmp_en, 0);
            if (chain_prev) check("spacing", cyc - last_valid, SC + N + 1);
            last_valid = cyc;
            chain_prev = keep_en;
            exp_dout = v;
            if (!keep_en) en = 1'b0;
         end
      end
   endtask

   // Start a conversion from IDLE: confirm idle, then raise en
   task automatic start_single(input logic [N-1:0] v);
      @(negedge clk);
      check_idle();
      en = 1'b1;
      run_conv(v, 1'b0);
   endtask

   // Drop en in cycle k (0-based from first SAMPLE cycle) and expect a clean abort
   task automatic run_abort(input logic [N-1:0] v, input int k);
      @(negedge clk);
      check_idle();
      en = 1'b1;
      vin = v;
      for (int c = 0; c <= k; c++) begin
         @(negedge clk);
         check("ab_busy", busy, 1);
      end
      en = 1'b0;
      chain_prev = 1'b0;
      @(negedge clk);
      check_idle();
      @(negedge clk);
      check_idle();
   endtask

   initial begin
      // Reset with en held high: reset must dominate
      rst_n = 1'b0;
      en    = 1'b1;
      repeat (3) @(negedge clk);
      check_reset_vals();
      rst_n = 1'b1;

      // First edge after release with en=1 starts tracking
      run_conv(8'hA5, 1'b0);

      // Boundary codes
      start_single(8'h00);
      start_single(8'hFF);

      // Continuous mode, three back-to-back results
      @(negedge clk);
      check_idle();
      en = 1'b1;
      run_conv(8'h3C, 1'b1);
      run_conv(8'h81, 1'b1);
      run_conv(8'h7F, 1'b0);

      // Abort in the 4th CONV cycle
      run_abort(8'h42, SC + 3);

      // Reset during CONV, then a fresh conversion
      @(negedge clk);
      en = 1'b1;
      vin = 8'h99;
      for (int c = 0; c < SC + 3; c++) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      exp_dout = '0;
      check_reset_vals();
      rst_n = 1'b1;
      chain_prev = 1'b0;
      run_conv(8'h5A, 1'b0);

      // Randomized continuous run
      @(negedge clk);
      check_idle();
      en = 1'b1;
      for (int r = 0; r < 20; r++) begin
         run_conv(N'($urandom_range(0, 255)), r != 19);
      end

      // Randomized aborts anywhere in SAMPLE or CONV
      for (int r = 0; r < 8; r++) begin
         run_abort(N'($urandom_range(0, 255)), int'($urandom_range(0, SC + N - 1)));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
